// File: rtl/right_shifter_seq.sv
// Sequential 32-bit right shifter: five barrel stages (16,8,4,2,1) applied one
// per clock, logical or arithmetic fill, fixed latency regardless of distance.
module right_shifter_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] data_in,
   input  logic [4:0]  shift_amount,
   input  logic        arithmetic,
   output logic [31:0] data_result,
   output logic        busy,
   output logic        result_ready
);

   // state | meaning
   // IDLE  | waiting for start; operands captured on the accepting edge
   // SHIFT | one barrel stage per edge, 16 down to 1
   // DONE  | result_ready pulse; returns to IDLE on the next edge
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state;
   logic [31:0] work;
   logic [4:0]  amt_q;
   logic        arith_q;
   logic        sign_q;
   logic [2:0]  stage_cnt;

   logic [4:0]  stage_dist;
   logic        stage_en;
   logic [31:0] fill_mask;
   logic [31:0] work_next;

   // stage_dist is one-hot and lines up with the shift_amount bit it serves
   always_comb begin
      stage_dist = 5'b10000 >> stage_cnt;
      stage_en   = |(amt_q & stage_dist);
      fill_mask  = ~(32'hFFFF_FFFF >> stage_dist);
      work_next  = work;
      if (stage_en)
         work_next = (work >> stage_dist) | (fill_mask & {32{arith_q & sign_q}});
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         work         <= '0;
         amt_q        <= '0;
         arith_q      <= 1'b0;
         sign_q       <= 1'b0;
         stage_cnt    <= '0;
         data_result  <= '0;
         busy         <= 1'b0;
         result_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work      <= data_in;
                  amt_q     <= shift_amount;
                  arith_q   <= arithmetic;
                  sign_q    <= data_in[31];
                  stage_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               work      <= work_next;
               stage_cnt <= stage_cnt + 3'd1;
               if (stage_cnt == 3'd4) begin
                  data_result  <= work_next;
                  result_ready <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               result_ready <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_right_shifter_seq.sv
// Scoreboard bench for right_shifter_seq: driver pushes expected results and
// issue cycles, a negedge monitor checks data, busy and pulse timing.
module tb_right_shifter_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] data_in;
   logic [4:0]  shift_amount;
   logic        arithmetic;
   logic [31:0] data_result;
   logic        busy;
   logic        result_ready;

   right_shifter_seq dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .data_in      (data_in),
      .shift_amount (shift_amount),
      .arithmetic   (arithmetic),
      .data_result  (data_result),
      .busy         (busy),
      .result_ready (result_ready)
   );

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          total = 0;
   int          passed = 0;
   logic [31:0] last_res = '0;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic a);
      if (a) return 32'($signed(d) >>> s);
      return d >> s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: latency is 6 cycles from the issuing negedge to the pulse negedge
   always @(negedge clock) begin
      bit exp_pulse, exp_busy;
      if (!reset) begin
         exp_pulse = (sb.size() > 0) && (sb[0].cyc + 6 == cyc);
         exp_busy  = (sb.size() > 0) && (cyc > sb[0].cyc) && (cyc <= sb[0].cyc + 6);
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("result_ready", 32'(result_ready), 32'(exp_pulse));
         if (exp_pulse) begin
            chk("data_result", data_result, sb[0].res);
            last_res = sb[0].res;
            void'(sb.pop_front());
         end else begin
            chk("data_result_hold", data_result, last_res);
         end
      end
   end

   // Called at a negedge; returns at the negedge where the next start would be accepted.
   task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic [31:0] exp, input bit hold, input bit lock);
      exp_t e;
      start = 1'b1; data_in = d; shift_amount = s; arithmetic = a;
      e.res = exp; e.cyc = cyc;
      sb.push_back(e);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clock);
         if (k < 7) begin
            data_in      = $urandom;
            shift_amount = 5'($urandom);
            arithmetic   = 1'($urandom);
            start        = hold || (lock && k == 2);
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [4:0]  s;
      logic        a;
      reset = 1'b1; start = 1'b0; data_in = '0; shift_amount = '0; arithmetic = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ready", 32'(result_ready), 32'd0);
      chk("reset_result", data_result, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      issue(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 0, 0);
      issue(32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 0, 0);
      issue(32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 0, 0);
      issue(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 0, 0);
      issue(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 0, 0);
      issue(32'h1234_5678, 5'd12, 1'b0, 32'h0001_2345, 0, 1);
      repeat (3) @(negedge clock);
      issue(32'hF000_0000, 5'd8,  1'b1, 32'hFFF0_0000, 1, 0);
      issue(32'h0000_FF00, 5'd8,  1'b0, 32'h0000_00FF, 0, 0);

      // Abort during the third SHIFT cycle
      start = 1'b1; data_in = 32'hCAFE_F00D; shift_amount = 5'd3; arithmetic = 1'b1;
      sb.push_back('{32'hF95F_DE01, cyc});
      @(negedge clock); start = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      sb.delete();
      last_res = '0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(result_ready), 32'd0);
      chk("abort_result", data_result, 32'h0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      issue(32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765, 0, 0);

      for (int i = 0; i < 40; i++) begin
         d = $urandom;
         s = 5'($urandom);
         a = 1'($urandom);
         issue(d, s, a, model(d, s, a), (i < 39) && ($urandom_range(0, 3) == 0),
               $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0 && !start) repeat ($urandom_range(1, 4)) @(negedge clock);
      end

      repeat (4) @(negedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
